adex_spike_isi_encoder: RTL and testbench

ADEX_SPIKE_ISI_ENCODER -- requirements
Module: adex_spike_isi_encoder

---
 rtl/adex_spike_isi_encoder_pkg.sv | 24 ++
 rtl/adex_isi_fifo.sv | 56 +++++
 rtl/adex_spike_isi_encoder.sv | 169 ++++++++++++++++
 tb/tb_adex_spike_isi_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/adex_spike_isi_encoder_pkg.sv
// Shared definitions for the AdEx spike inter-spike-interval encoder:
// serializer state encodings, frame header nibbles and default widths.
package adex_spike_isi_encoder_pkg;

    localparam int unsigned ISI_W_DEFAULT = 12;
    // A frame always carries three interval nibbles.
    localparam int unsigned ISI_FIELD_W   = 12;

    localparam logic [3:0] HDR_FIRST = 4'hB;
    localparam logic [3:0] HDR_NORM  = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_N2   = 3'd2,
        S_N1   = 3'd3,
        S_N0   = 3'd4
    } ser_state_t;

    function automatic logic [3:0] hdr_nibble(input logic first_tag);
        return first_tag ? HDR_FIRST : HDR_NORM;
    endfunction

endpackage

// File: rtl/adex_isi_fifo.sv
// Interval FIFO (power-of-two depth). A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped.
module adex_isi_fifo #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/adex_spike_isi_encoder.sv
// Measures intervals between AdEx spikes and streams them as 4-nibble frames.
// Optional macro ADEX_SPIKE_RATE_EN adds a windowed spike-rate output.
module adex_spike_isi_encoder
    import adex_spike_isi_encoder_pkg::*;
#(
    parameter int unsigned ISI_W       = ISI_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned RATE_WINDOW = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spike_in,
    input  logic       enable,
    input  logic       clr_ovf,
    input  logic       nib_ack,
    output logic [3:0] nib_out,
    output logic       nib_valid,
    output logic       ovf,
    output logic [2:0] fifo_level
`ifdef ADEX_SPIKE_RATE_EN
    ,
    output logic [7:0] spike_rate
`endif
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] isi_inc;
    logic             first_tag;
    logic             spike_ev;

    logic             fifo_pop;
    logic [ISI_W:0]   fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_lvl;
    logic             ovf_ev;

    ser_state_t            state;
    ser_state_t            state_next;
    logic [ISI_FIELD_W-1:0] hold_isi;
    logic                   hold_tag;

    assign spike_ev = enable & spike_in;
    assign isi_inc  = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isi_cnt   <= '0;
            first_tag <= 1'b1;
        end else if (enable) begin
            if (spike_in) begin
                isi_cnt   <= '0;
                first_tag <= 1'b0;
            end else begin
                isi_cnt <= isi_inc;
            end
        end
    end

    adex_isi_fifo #(
        .DATA_W (ISI_W + 1),
        .DEPTH  (FIFO_DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (spike_ev),
        .push_data ({first_tag, isi_inc}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_lvl)
    );

    assign fifo_level = 3'(fifo_lvl);

    // A same-cycle pop frees the slot, so only a push without pop overflows.
    assign ovf_ev = spike_ev & fifo_full & ~fifo_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ovf <= 1'b0;
        else if (ovf_ev)  ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_isi <= '0;
            hold_tag <= 1'b0;
        end else if (fifo_pop) begin
            hold_isi <= ISI_FIELD_W'(fifo_rd[ISI_W-1:0]);
            hold_tag <= fifo_rd[ISI_W];
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        nib_valid  = 1'b1;
        nib_out    = '0;
        case (state)
            S_IDLE: begin
                nib_valid = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                nib_out = hdr_nibble(hold_tag);
                if (nib_ack) state_next = S_N2;
            end
            S_N2: begin
                nib_out = hold_isi[11:8];
                if (nib_ack) state_next = S_N1;
            end
            S_N1: begin
                nib_out = hold_isi[7:4];
                if (nib_ack) state_next = S_N0;
            end
            S_N0: begin
                nib_out = hold_isi[3:0];
                if (nib_ack) state_next = S_IDLE;
            end
            default: begin
                nib_valid  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef ADEX_SPIKE_RATE_EN
    localparam int unsigned WIN_W = (RATE_WINDOW > 1) ? $clog2(RATE_WINDOW) : 1;

    logic [WIN_W-1:0] win_cnt;
    logic [7:0]       rate_acc;
    logic [7:0]       rate_inc;
    logic             win_last;

    assign win_last = (win_cnt == WIN_W'(RATE_WINDOW - 1));
    assign rate_inc = (rate_acc == 8'hFF) ? 8'hFF : rate_acc + 1'b1;

    // The last cycle's spike belongs to the window being published.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt    <= '0;
            rate_acc   <= '0;
            spike_rate <= '0;
        end else if (win_last) begin
            win_cnt    <= '0;
            rate_acc   <= '0;
            spike_rate <= spike_ev ? rate_inc : rate_acc;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (spike_ev) rate_acc <= rate_inc;
        end
    end
`endif

endmodule

// File: tb/tb_adex_spike_isi_encoder.sv
// Directed bench for adex_spike_isi_encoder with a frame scoreboard.
module tb_adex_spike_isi_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       spike_in;
    logic       enable;
    logic       clr_ovf;
    logic       nib_ack;
    logic [3:0] nib_out;
    logic       nib_valid;
    logic       ovf;
    logic [2:0] fifo_level;
`ifdef ADEX_SPIKE_RATE_EN
    logic [7:0] spike_rate;
`endif

    int checks   = 0;
    int failures = 0;
    int frames   = 0;

    logic [15:0] sb [$];
    int          m_cnt;
    logic        m_tag;
    bit          drop_next;
    logic [15:0] cur     = '0;
    int          nib_idx = 0;
    int          f0;

    adex_spike_isi_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .spike_in   (spike_in),
        .enable     (enable),
        .clr_ovf    (clr_ovf),
        .nib_ack    (nib_ack),
        .nib_out    (nib_out),
        .nib_valid  (nib_valid),
        .ovf        (ovf),
        .fifo_level (fifo_level)
`ifdef ADEX_SPIKE_RATE_EN
        ,
        .spike_rate (spike_rate)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Collect nibbles on the falling edge; a handshake completes at the next rise.
    always @(negedge clk) begin
        if (reset) begin
            nib_idx = 0;
        end else if (nib_valid && nib_ack) begin
            cur = {cur[11:0], nib_out};
            nib_idx++;
            if (nib_idx == 4) begin
                nib_idx = 0;
                frames++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_frame observed=%0h expected=none", cur);
                end else begin
                    chk("frame", {16'h0, cur}, {16'h0, sb.pop_front()});
                end
            end
        end
    end

    // Drive one cycle and advance the reference interval model at that edge.
    task automatic step(input bit sp, input bit en);
        int val;
        spike_in = sp;
        enable   = en;
        @(posedge clk);
        if (en) begin
            val = (m_cnt + 1 > 4095) ? 4095 : m_cnt + 1;
            if (sp) begin
                if (!drop_next) sb.push_back({m_tag ? 4'hB : 4'hA, 12'(val)});
                m_cnt = 0;
                m_tag = 1'b0;
            end else begin
                m_cnt = val;
            end
        end
        #1;
        spike_in = 1'b0;
    endtask

    task automatic drain(input bit en, input int budget);
        int n = 0;
        while (n < budget && !(sb.size() == 0 && !nib_valid && fifo_level == 3'd0)) begin
            step(1'b0, en);
            n++;
        end
        chk("drain", {30'h0, sb.size() == 0, nib_valid}, 32'h2);
    endtask

    initial begin
        reset = 1'b1; spike_in = 1'b0; enable = 1'b0; clr_ovf = 1'b0; nib_ack = 1'b1;
        m_cnt = 0; m_tag = 1'b1; drop_next = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", nib_valid, 0);
        chk("rst_nib", nib_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_level", fifo_level, 0);
        reset = 1'b0;

        // Spikes 100 cycles apart: first frame tagged, latency of one edge.
        repeat (10) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("lat_pre_valid", nib_valid, 0);
        chk("lat_level", fifo_level, 1);
        step(1'b0, 1'b1);
        chk("lat_valid", nib_valid, 1);
        chk("lat_hdr", nib_out, 4'hB);
        repeat (98) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        drain(1'b1, 200);

        // Disabled gap must not count and disabled spikes must not push.
        step(1'b1, 1'b1);
        drain(1'b0, 200);
        repeat (10) step(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) step(i % 7 == 3, 1'b0);
        repeat (9) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        drain(1'b1, 200);

        // Saturating interval.
        repeat (5000) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        drain(1'b1, 200);

        // Overflow with the consumer stalled.
        f0 = frames;
        nib_ack = 1'b0;
        repeat (5) step(1'b1, 1'b1);
        drop_next = 1'b1;
        step(1'b1, 1'b1);
        drop_next = 1'b0;
        chk("ovf_level", fifo_level, 4);
        chk("ovf_set", ovf, 1);
        chk("stall_valid", nib_valid, 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold", nib_out, 4'hA);
            step(1'b0, 1'b1);
        end
        clr_ovf = 1'b1;
        drop_next = 1'b1;
        step(1'b1, 1'b1);
        drop_next = 1'b0;
        chk("ovf_clr_collide", ovf, 1);
        step(1'b0, 1'b1);
        clr_ovf = 1'b0;
        chk("ovf_cleared", ovf, 0);
        nib_ack = 1'b1;
        repeat (4) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("full_pushpop_ovf", ovf, 0);
        chk("full_pushpop_level", fifo_level, 4);
        drain(1'b1, 400);
        chk("ovf_frames", frames - f0, 6);

        // Reset in the middle of a frame.
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        chk("pre_reset_valid", nib_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", nib_valid, 0);
        chk("async_rst_nib", nib_out, 0);
        chk("async_rst_level", fifo_level, 0);
        sb.delete();
        m_cnt = 0;
        m_tag = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("post_rst_hdr", nib_out, 4'hB);
        drain(1'b1, 200);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
